seq_divider: RTL and testbench
==============================

SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, operand and result width in bits, legal range 2..64.
REQ-002 The block SHALL have parameter SIGNED_EN, default 1; 0 removes signed support and treats in_signed as 0.
REQ-003 The block SHALL have port clk, input, 1 bit, clock; all logic rising-edge.
REQ-004 The block SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit, operands present.
REQ-006 The block SHALL have port in_ready, output, 1 bit, block accepts operands.
REQ-007 The block SHALL have port in_signed, input, 1 bit, two's-complement operation when 1.
REQ-008 The block SHALL have port dvd, input, WIDTH bits, dividend.
REQ-009 The block SHALL have port dvs, input, WIDTH bits, divisor.
REQ-010 The block SHALL have port out_valid, output, 1 bit, result present.
REQ-011 The block SHALL have port out_ready, input, 1 bit, consumer accepts result.
REQ-012 The block SHALL have port quo, output, WIDTH bits, quotient.
REQ-013 The block SHALL have port rem, output, WIDTH bits, remainder.
REQ-014 The block SHALL have port dbz, output, 1 bit, divide-by-zero flag, qualified by out_valid.
REQ-015 The block SHALL have port busy, output, 1 bit, high in every state except IDLE.

Function
REQ-016 The FSM SHALL have states IDLE, CALC, FIX, DONE; in_ready SHALL be 1 only in IDLE.
REQ-017 Accept SHALL occur at cycle T when in_valid and in_ready are both 1; dvd, dvs and in_signed SHALL be registered at T and later input changes ignored.
REQ-018 When dvs is non-zero, IDLE->CALC SHALL occur at T+1.
REQ-019 CALC SHALL run restoring division on operand magnitudes, one quotient bit per cycle MSB first, for exactly WIDTH cycles (T+1..T+WIDTH), then go to FIX.
REQ-020 FIX SHALL last one cycle (T+WIDTH+1): it negates the quotient when the operand signs differ in signed mode, and negates the remainder when the dividend is negative in signed mode.
REQ-021 out_valid SHALL rise at T+WIDTH+2 with state DONE; the unsigned-mode latency is identical.
REQ-022 When dvs is zero, the block SHALL go IDLE->DONE at T+1 with quo all ones, rem equal to dvd, and dbz 1; dbz SHALL be 0 for every other result.
REQ-023 Signed overflow (dvd = most negative, dvs = -1) SHALL give quo equal to the most-negative value and rem 0, with dbz 0.
REQ-024 Magnitude arithmetic SHALL use WIDTH+1-bit intermediates so that the magnitude 2^(WIDTH-1) is exact.
REQ-025 In DONE, quo, rem and dbz SHALL be held stable while out_ready is 0; there is no timeout.
REQ-026 DONE->IDLE SHALL occur on the cycle where out_valid and out_ready are both 1; in_ready SHALL rise the next cycle, giving a minimum accept spacing of WIDTH+3 cycles.
REQ-027 quo and rem SHALL hold the last result after DONE until the next result is loaded; they are undefined for consumers unless out_valid is 1.
REQ-028 in_valid asserted outside IDLE SHALL be ignored and SHALL NOT be queued.

Reset
REQ-029 While rst is 1 the block SHALL enter IDLE, with out_valid, quo, rem, dbz and busy 0 and in_ready 1 from the cycle after rst is sampled.
REQ-030 rst asserted in CALC, FIX or DONE SHALL abort the operation with no out_valid pulse; the first accept after rst deasserts SHALL behave as from power-up.

Verification (WIDTH=8, SIGNED_EN=1)
REQ-031 Bench SHALL check: unsigned 100/7 accepted at T -> out_valid at T+10, quo=14, rem=2, dbz=0.
REQ-032 Bench SHALL check: signed -7/2 (0xF9/0x02) -> quo=0xFD (-3), rem=0xFF (-1); signed 7/-2 -> quo=0xFD, rem=0x01.
REQ-033 Bench SHALL check: 0x55/0 in either mode -> out_valid at T+1, quo=0xFF, rem=0x55, dbz=1.
REQ-034 Bench SHALL check: signed 0x80/0xFF -> quo=0x80, rem=0x00, dbz=0; unsigned 0x80/0xFF -> quo=0, rem=0x80.
REQ-035 Bench SHALL check: out_ready held 0 for 5 cycles after out_valid -> quo/rem stable, in_ready=0, and in_valid ignored; in_ready=1 on the cycle after the handshake.
REQ-036 Bench SHALL check: rst pulsed at T+4 of 200/3 -> no out_valid pulse, all outputs 0, and a new 9/3 accept returns quo=3, rem=0 at its T+10.

Source files
------------

// File: rtl/seq_divider.sv
// Sequential restoring divider with valid/ready handshakes on both sides.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   operands present
//   in_ready   block accepts operands (IDLE only)
//   in_signed  two's-complement operation when 1 (forced to 0 when SIGNED_EN == 0)
//   dvd, dvs   dividend and divisor, WIDTH bits
//   out_valid  result present
//   out_ready  consumer accepts result
//   quo, rem   quotient and remainder, held until the next result is loaded
//   dbz        divide-by-zero flag, qualified by out_valid
//   busy       high in every state except IDLE
//
// Timing: operands accepted at cycle T give out_valid at T+WIDTH+2
// (WIDTH CALC cycles plus one FIX cycle). A zero divisor skips straight to DONE at T+1.
module seq_divider #(
    parameter int WIDTH     = 16,
    parameter int SIGNED_EN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_signed,
    input  logic [WIDTH-1:0] dvd,
    input  logic [WIDTH-1:0] dvs,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quo,
    output logic [WIDTH-1:0] rem,
    output logic             dbz,
    output logic             busy
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shq;      // dividend bits shift out at the top, quotient bits shift in
    logic [WIDTH-1:0] prem;     // partial remainder
    logic [WIDTH:0]   dvs_mag;
    logic             q_neg;
    logic             r_neg;
    logic [CW-1:0]    cnt;

    // Operand magnitudes use WIDTH+1 bits so that |most negative| is exact.
    logic             sgn_mode;
    logic [WIDTH:0]   dvd_ext;
    logic [WIDTH:0]   dvs_ext;
    logic [WIDTH:0]   dvd_abs;
    logic [WIDTH:0]   dvs_abs;

    // One restoring step.
    logic [WIDTH:0]   trial;
    logic             take;
    logic [WIDTH-1:0] prem_nxt;

    always_comb begin
        sgn_mode = (SIGNED_EN != 0) && in_signed;
        dvd_ext  = {sgn_mode & dvd[WIDTH-1], dvd};
        dvs_ext  = {sgn_mode & dvs[WIDTH-1], dvs};
        dvd_abs  = dvd_ext[WIDTH] ? (~dvd_ext + 1'b1) : dvd_ext;
        dvs_abs  = dvs_ext[WIDTH] ? (~dvs_ext + 1'b1) : dvs_ext;

        trial    = {prem, shq[WIDTH-1]};
        take     = (trial >= dvs_mag);
        // When take is set the true difference is below the divisor, so WIDTH bits suffice.
        prem_nxt = take ? (trial[WIDTH-1:0] - dvs_mag[WIDTH-1:0]) : trial[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            quo       <= '0;
            rem       <= '0;
            dbz       <= 1'b0;
            shq       <= '0;
            prem      <= '0;
            dvs_mag   <= '0;
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        if (dvs == '0) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            quo       <= '1;
                            rem       <= dvd;
                            dbz       <= 1'b1;
                        end else begin
                            state   <= CALC;
                            shq     <= dvd_abs[WIDTH-1:0];
                            // Top magnitude bit (always 0 here) preloads the partial remainder,
                            // so exactly WIDTH steps cover the WIDTH+1-bit dividend.
                            prem    <= {{(WIDTH - 1){1'b0}}, dvd_abs[WIDTH]};
                            dvs_mag <= dvs_abs;
                            q_neg   <= dvd_ext[WIDTH] ^ dvs_ext[WIDTH];
                            r_neg   <= dvd_ext[WIDTH];
                            cnt     <= '0;
                        end
                    end
                end
                CALC: begin
                    shq  <= {shq[WIDTH-2:0], take};
                    prem <= prem_nxt;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    // Overflow (most negative / -1) truncates naturally to the most negative value.
                    quo       <= q_neg ? (~shq + 1'b1) : shq;
                    rem       <= r_neg ? (~prem + 1'b1) : prem;
                    dbz       <= 1'b0;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed and random checks of seq_divider (WIDTH=8, SIGNED_EN=1) using a result scoreboard.
module tb_seq_divider;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic         in_signed;
    logic [W-1:0] dvd;
    logic [W-1:0] dvs;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] quo;
    logic [W-1:0] rem;
    logic         dbz;
    logic         busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       z;
        int         lat;
    } exp_t;

    exp_t sb[$];

    seq_divider #(
        .WIDTH    (W),
        .SIGNED_EN(1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_signed(in_signed),
        .dvd      (dvd),
        .dvs      (dvs),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .quo      (quo),
        .rem      (rem),
        .dbz      (dbz),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] q, input logic [7:0] r, input logic z,
                                input int lat);
        exp_t e;
        e.q   = q;
        e.r   = r;
        e.z   = z;
        e.lat = lat;
        return e;
    endfunction

    // Reference model using integer division (truncation toward zero).
    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic s);
        int ia;
        int ib;
        int q;
        int r;
        if (b == 8'h00) return mk(8'hFF, a, 1'b1, 1);
        if (s) begin
            ia = int'($signed(a));
            ib = int'($signed(b));
        end else begin
            ia = int'(a);
            ib = int'(b);
        end
        q = ia / ib;
        r = ia % ib;
        return mk(q[7:0], r[7:0], 1'b0, W + 2);
    endfunction

    // Issue one operation, scoreboard it, check latency/result, optionally stall out_ready.
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic s, input exp_t e_in, input int hold);
        exp_t e;
        int   lat;
        int   w;
        @(negedge clk);
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk({tag, ".in_ready"}, 64'(in_ready), 64'(1));
        dvd       = a;
        dvs       = b;
        in_signed = s;
        in_valid  = 1'b1;
        @(posedge clk);
        sb.push_back(e_in);
        @(negedge clk);
        // Scramble operands to show they were captured at accept.
        in_valid  = 1'b0;
        dvd       = ~a;
        dvs       = 8'h01;
        in_signed = ~s;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        e = sb.pop_front();
        chk({tag, ".latency"}, 64'(lat), 64'(e.lat));
        chk({tag, ".quo"}, 64'(quo), 64'(e.q));
        chk({tag, ".rem"}, 64'(rem), 64'(e.r));
        chk({tag, ".dbz"}, 64'(dbz), 64'(e.z));
        for (int i = 0; i < hold; i++) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            dvd       = 8'h11;
            dvs       = 8'h02;
            in_signed = 1'b0;
            @(negedge clk);
            chk({tag, ".hold_valid"}, 64'(out_valid), 64'(1));
            chk({tag, ".hold_quo"}, 64'(quo), 64'(e.q));
            chk({tag, ".hold_rem"}, 64'(rem), 64'(e.r));
            chk({tag, ".hold_in_ready"}, 64'(in_ready), 64'(0));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, ".post_valid"}, 64'(out_valid), 64'(0));
        chk({tag, ".post_in_ready"}, 64'(in_ready), 64'(1));
        chk({tag, ".post_busy"}, 64'(busy), 64'(0));
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rs;
        int         seen;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_signed = 1'b0;
        dvd       = '0;
        dvs       = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset.in_ready", 64'(in_ready), 64'(1));
        chk("reset.out_valid", 64'(out_valid), 64'(0));
        chk("reset.quo", 64'(quo), 64'(0));
        chk("reset.rem", 64'(rem), 64'(0));
        chk("reset.dbz", 64'(dbz), 64'(0));
        chk("reset.busy", 64'(busy), 64'(0));
        rst = 1'b0;

        run_op("u100_7", 8'd100, 8'd7, 1'b0, mk(8'd14, 8'd2, 1'b0, 10), 0);
        run_op("s_m7_2", 8'hF9, 8'h02, 1'b1, mk(8'hFD, 8'hFF, 1'b0, 10), 0);
        run_op("s_7_m2", 8'h07, 8'hFE, 1'b1, mk(8'hFD, 8'h01, 1'b0, 10), 0);
        run_op("u_dbz", 8'h55, 8'h00, 1'b0, mk(8'hFF, 8'h55, 1'b1, 1), 0);
        run_op("s_dbz", 8'h55, 8'h00, 1'b1, mk(8'hFF, 8'h55, 1'b1, 1), 0);
        run_op("s_ovf", 8'h80, 8'hFF, 1'b1, mk(8'h80, 8'h00, 1'b0, 10), 0);
        run_op("u_80_ff", 8'h80, 8'hFF, 1'b0, mk(8'h00, 8'h80, 1'b0, 10), 0);
        run_op("u_255_1", 8'hFF, 8'h01, 1'b0, mk(8'hFF, 8'h00, 1'b0, 10), 0);
        run_op("hold", 8'd200, 8'd13, 1'b0, mk(8'd15, 8'd5, 1'b0, 10), 5);

        // Reset in the middle of CALC aborts the operation.
        @(negedge clk);
        dvd       = 8'd200;
        dvs       = 8'd3;
        in_signed = 1'b0;
        in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort.out_valid", 64'(out_valid), 64'(0));
        chk("abort.quo", 64'(quo), 64'(0));
        chk("abort.rem", 64'(rem), 64'(0));
        chk("abort.dbz", 64'(dbz), 64'(0));
        chk("abort.busy", 64'(busy), 64'(0));
        chk("abort.in_ready", 64'(in_ready), 64'(1));
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("abort.no_pulse", 64'(seen), 64'(0));
        run_op("after_rst", 8'd9, 8'd3, 1'b0, mk(8'd3, 8'd0, 1'b0, 10), 0);

        for (int i = 0; i < 10; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rs = 1'($urandom_range(0, 1));
            run_op($sformatf("rnd%0d", i), ra, rb, rs, model(ra, rb, rs), i % 3);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
